// File: rtl/invaders_pkg.sv
// -----------------------------------------------------------------------------
// invaders_pkg
// Shared types and constants for the invader-side game objects.
//   coord_t       : signed 16-bit screen coordinate
//   bomb_state_t  : one-hot alien bomb state
//   BOMB_COLOR    : colour index while the bomb is falling
//   EXPLODE_COLOR : colour index while the bomb is exploding
//   BULLET_W/H    : footprint of the player's bullet (used by bomb cancel)
// -----------------------------------------------------------------------------
package invaders_pkg;

    typedef logic signed [15:0] coord_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_FALLING   = 4'b0010,
        ST_EXPLODING = 4'b0100,
        ST_COOLDOWN  = 4'b1000
    } bomb_state_t;

    localparam logic [3:0] BOMB_COLOR    = 4'hC;
    localparam logic [3:0] EXPLODE_COLOR = 4'hE;

    localparam int BULLET_W = 2;
    localparam int BULLET_H = 8;

endpackage

// File: rtl/alien_bomb_if.sv
// -----------------------------------------------------------------------------
// alien_bomb_if
// Bundles the alien bomb's game-side and video-side signals.
//   master : the game/video logic driving the bomb (drop request, frame tick,
//            raster position, ship position, speed) and observing its outputs
//   slave  : the alien_bomb block itself
// Optional macro BOMB_CANCEL_EN adds bullet_x/bullet_y/bullet_active inputs
// and the cancel output.
// -----------------------------------------------------------------------------
interface alien_bomb_if;
    import invaders_pkg::*;

    logic        drop;
    coord_t      drop_x;
    coord_t      drop_y;
    logic        frame;
    logic        screen_line;
    logic [7:0]  speed;
    coord_t      screen_x;
    coord_t      screen_y;
    coord_t      spaceship_x;
    coord_t      spaceship_y;
    logic        drawing;
    logic [3:0]  pixel;
    coord_t      bomb_x;
    coord_t      bomb_y;
    logic [3:0]  bomb_state;
    logic        hit;
`ifdef BOMB_CANCEL_EN
    coord_t      bullet_x;
    coord_t      bullet_y;
    logic        bullet_active;
    logic        cancel;
`endif

    modport master (
        output drop, drop_x, drop_y, frame, screen_line, speed,
               screen_x, screen_y, spaceship_x, spaceship_y,
`ifdef BOMB_CANCEL_EN
        output bullet_x, bullet_y, bullet_active,
        input  cancel,
`endif
        input  drawing, pixel, bomb_x, bomb_y, bomb_state, hit
    );

    modport slave (
        input  drop, drop_x, drop_y, frame, screen_line, speed,
               screen_x, screen_y, spaceship_x, spaceship_y,
`ifdef BOMB_CANCEL_EN
        input  bullet_x, bullet_y, bullet_active,
        output cancel,
`endif
        output drawing, pixel, bomb_x, bomb_y, bomb_state, hit
    );

endinterface

// File: rtl/rect_overlap.sv
// -----------------------------------------------------------------------------
// rect_overlap
// Combinational test of whether two axis-aligned rectangles overlap.
// Each rectangle covers the half-open ranges [x, x+w) and [y, y+h), so
// rectangles that merely share an edge do not overlap. Signed compares.
//   a_x, a_y, a_w, a_h : first rectangle
//   b_x, b_y, b_w, b_h : second rectangle
//   overlap            : 1 when the rectangles share at least one pixel
// -----------------------------------------------------------------------------
module rect_overlap
    import invaders_pkg::*;
(
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t a_w,
    input  coord_t a_h,
    input  coord_t b_x,
    input  coord_t b_y,
    input  coord_t b_w,
    input  coord_t b_h,
    output logic   overlap
);

    coord_t a_x_end;
    coord_t a_y_end;
    coord_t b_x_end;
    coord_t b_y_end;

    assign a_x_end = a_x + a_w;
    assign a_y_end = a_y + a_h;
    assign b_x_end = b_x + b_w;
    assign b_y_end = b_y + b_h;

    assign overlap = (a_x < b_x_end) && (b_x < a_x_end) &&
                     (a_y < b_y_end) && (b_y < a_y_end);

endmodule

// File: rtl/alien_bomb.sv
// -----------------------------------------------------------------------------
// alien_bomb
// Bomb dropped by the invader formation. Latches a launch position on a drop
// request, falls by `speed` pixels per frame, reports a one-cycle hit when it
// strikes the spaceship, explodes, cools down and becomes available again.
// Also produces the registered drawing/pixel pair for the video mixer.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : alien_bomb_if.slave (drop request, frame tick, raster, ship
//          position in; drawing, pixel, bomb_x/bomb_y, bomb_state, hit out)
// Optional macro BOMB_CANCEL_EN: the player's bullet can cancel a falling
// bomb (cancel output); a ship hit on the same frame wins.
// -----------------------------------------------------------------------------
module alien_bomb
    import invaders_pkg::*;
#(
    parameter int SCREEN_H        = 480,
    parameter int BOMB_W          = 2,
    parameter int BOMB_H          = 8,
    parameter int SHIP_W          = 32,
    parameter int SHIP_H          = 16,
    parameter int EXPLODE_FRAMES  = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic         clk,
    input  logic         rst,
    alien_bomb_if.slave  bus
);

    bomb_state_t state;
    coord_t      bomb_x;
    coord_t      bomb_y;
    logic [15:0] frame_cnt;
    logic        hit_r;
    logic        drawing_r;
    logic [3:0]  pixel_r;

    coord_t      next_y;
    logic        ship_overlap;
    logic        raster_overlap;
    logic        bullet_hit;
    logic        bomb_visible;
    logic        draw_next;

    // Position the bomb would take on this frame; the hit and off-screen tests
    // look at this new position, not the current one.
    assign next_y = bomb_y + coord_t'({8'b0, bus.speed});

    rect_overlap u_ship_hit (
        .a_x     (bomb_x),
        .a_y     (next_y),
        .a_w     (coord_t'(BOMB_W)),
        .a_h     (coord_t'(BOMB_H)),
        .b_x     (bus.spaceship_x),
        .b_y     (bus.spaceship_y),
        .b_w     (coord_t'(SHIP_W)),
        .b_h     (coord_t'(SHIP_H)),
        .overlap (ship_overlap)
    );

    // The raster position is treated as a 1x1 rectangle.
    rect_overlap u_raster (
        .a_x     (bus.screen_x),
        .a_y     (bus.screen_y),
        .a_w     (16'sd1),
        .a_h     (16'sd1),
        .b_x     (bomb_x),
        .b_y     (bomb_y),
        .b_w     (coord_t'(BOMB_W)),
        .b_h     (coord_t'(BOMB_H)),
        .overlap (raster_overlap)
    );

`ifdef BOMB_CANCEL_EN
    logic bullet_overlap;
    logic cancel_r;

    rect_overlap u_bullet_hit (
        .a_x     (bomb_x),
        .a_y     (next_y),
        .a_w     (coord_t'(BOMB_W)),
        .a_h     (coord_t'(BOMB_H)),
        .b_x     (bus.bullet_x),
        .b_y     (bus.bullet_y),
        .b_w     (coord_t'(BULLET_W)),
        .b_h     (coord_t'(BULLET_H)),
        .overlap (bullet_overlap)
    );

    assign bullet_hit = bus.bullet_active && bullet_overlap;
    assign bus.cancel = cancel_r;
`else
    assign bullet_hit = 1'b0;
`endif

    assign bomb_visible = (state == ST_FALLING) || (state == ST_EXPLODING);
    assign draw_next    = bus.screen_line && bomb_visible && raster_overlap;

    // NOTE: every register below is assigned with <= so all of them update from
    // the same pre-edge values; blocking '=' here would let later statements
    // see half-updated state and simulate differently from the netlist.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bomb_x    <= '0;
            bomb_y    <= '0;
            frame_cnt <= '0;
            hit_r     <= 1'b0;
            drawing_r <= 1'b0;
            pixel_r   <= 4'h0;
`ifdef BOMB_CANCEL_EN
            cancel_r  <= 1'b0;
`endif
        end else begin
            hit_r     <= 1'b0;
`ifdef BOMB_CANCEL_EN
            cancel_r  <= 1'b0;
`endif
            drawing_r <= draw_next;
            pixel_r   <= !draw_next                ? 4'h0 :
                         (state == ST_FALLING)     ? BOMB_COLOR : EXPLODE_COLOR;

            case (state)
                ST_IDLE: begin
                    // A frame tick in the launch cycle does not move the bomb.
                    if (bus.drop) begin
                        bomb_x <= bus.drop_x;
                        bomb_y <= bus.drop_y;
                        state  <= ST_FALLING;
                    end
                end

                ST_FALLING: begin
                    if (bus.frame) begin
                        bomb_y <= next_y;
                        if (ship_overlap) begin
                            hit_r     <= 1'b1;
                            state     <= ST_EXPLODING;
                            frame_cnt <= 16'(EXPLODE_FRAMES - 1);
                        end else if (bullet_hit) begin
`ifdef BOMB_CANCEL_EN
                            cancel_r  <= 1'b1;
`endif
                            state     <= ST_EXPLODING;
                            frame_cnt <= 16'(EXPLODE_FRAMES - 1);
                        end else if (next_y >= coord_t'(SCREEN_H)) begin
                            state     <= ST_COOLDOWN;
                            frame_cnt <= 16'(COOLDOWN_FRAMES - 1);
                        end
                    end
                end

                ST_EXPLODING: begin
                    if (bus.frame) begin
                        if (frame_cnt == '0) begin
                            state     <= ST_COOLDOWN;
                            frame_cnt <= 16'(COOLDOWN_FRAMES - 1);
                        end else begin
                            frame_cnt <= frame_cnt - 16'd1;
                        end
                    end
                end

                ST_COOLDOWN: begin
                    if (bus.frame) begin
                        if (frame_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt - 16'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bomb_x     = bomb_x;
    assign bus.bomb_y     = bomb_y;
    assign bus.bomb_state = state;
    assign bus.hit        = hit_r;
    assign bus.drawing    = drawing_r;
    assign bus.pixel      = pixel_r;

endmodule

// File: tb/tb_alien_bomb.sv
// -----------------------------------------------------------------------------
// tb_alien_bomb
// Directed bench for alien_bomb. The stimulus process pushes the expected
// observable state into a queue one cycle at a time; a monitor process on the
// falling clock edge pops each entry and compares it with the DUT outputs.
// Optional macro BOMB_CANCEL_EN exercises the bullet cancel path.
// -----------------------------------------------------------------------------
module tb_alien_bomb;
    import invaders_pkg::*;

    typedef struct packed {
        logic [3:0]  state;
        logic [15:0] x;
        logic [15:0] y;
        logic        hit;
        logic        drawing;
        logic [3:0]  pixel;
        logic        cancel;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alien_bomb_if bus ();

    alien_bomb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    passes   = 0;
    int    hit_seen = 0;

    // Monitor: compares one queued expectation per falling edge.
    always @(negedge clk) begin : monitor
        obs_t  e;
        obs_t  a;
        string n;
        if (bus.hit === 1'b1) hit_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.state   = bus.bomb_state;
            a.x       = bus.bomb_x;
            a.y       = bus.bomb_y;
            a.hit     = bus.hit;
            a.drawing = bus.drawing;
            a.pixel   = bus.pixel;
`ifdef BOMB_CANCEL_EN
            a.cancel  = bus.cancel;
`else
            a.cancel  = 1'b0;
`endif
            checks++;
            if (a === e) begin
                passes++;
            end else begin
                $display("FAIL %s: got st=%b x=%0d y=%0d hit=%b draw=%b pix=%h cancel=%b; expected st=%b x=%0d y=%0d hit=%b draw=%b pix=%h cancel=%b",
                         n, a.state, $signed(a.x), $signed(a.y), a.hit, a.drawing, a.pixel, a.cancel,
                         e.state, $signed(e.x), $signed(e.y), e.hit, e.drawing, e.pixel, e.cancel);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle followed by a one-clk frame pulse; returns just after the
    // edge that consumed the pulse.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.frame = 1'b1;
            tick();
            bus.frame = 1'b0;
        end
    endtask

    task automatic expect_obs(input string name, input logic [3:0] st,
                              input int x, input int y, input logic h,
                              input logic d, input logic [3:0] p, input logic c);
        obs_t e;
        e.state   = st;
        e.x       = 16'(x);
        e.y       = 16'(y);
        e.hit     = h;
        e.drawing = d;
        e.pixel   = p;
        e.cancel  = c;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_FALL = 4'b0010;
    localparam logic [3:0] S_EXPL = 4'b0100;
    localparam logic [3:0] S_COOL = 4'b1000;

    initial begin
        rst             = 1'b1;
        bus.drop        = 1'b0;
        bus.drop_x      = '0;
        bus.drop_y      = '0;
        bus.frame       = 1'b0;
        bus.screen_line = 1'b0;
        bus.speed       = 8'd4;
        bus.screen_x    = '0;
        bus.screen_y    = '0;
        bus.spaceship_x = 16'sd300;
        bus.spaceship_y = 16'sd400;
`ifdef BOMB_CANCEL_EN
        bus.bullet_x      = '0;
        bus.bullet_y      = '0;
        bus.bullet_active = 1'b0;
`endif

        tick();
        tick();
        rst = 1'b0;
        expect_obs("reset_init", S_IDLE, 0, 0, 0, 0, 4'h0, 0);
        tick();

        // Miss path; the frame pulse in the launch cycle must not move the bomb.
        bus.drop   = 1'b1;
        bus.drop_x = 16'sd100;
        bus.drop_y = 16'sd50;
        bus.frame  = 1'b1;
        tick();
        bus.drop  = 1'b0;
        bus.frame = 1'b0;
        expect_obs("drop_latch", S_FALL, 100, 50, 0, 0, 4'h0, 0);

        // Raster test against rect x [100,102), y [50,58).
        bus.screen_line = 1'b1;
        bus.screen_x    = 16'sd101;
        bus.screen_y    = 16'sd57;
        tick();
        expect_obs("raster_in", S_FALL, 100, 50, 0, 1, 4'hC, 0);
        bus.screen_y = 16'sd58;
        tick();
        expect_obs("raster_below", S_FALL, 100, 50, 0, 0, 4'h0, 0);
        bus.screen_x = 16'sd102;
        bus.screen_y = 16'sd57;
        tick();
        expect_obs("raster_right", S_FALL, 100, 50, 0, 0, 4'h0, 0);
        bus.screen_x    = 16'sd101;
        bus.screen_line = 1'b0;
        tick();
        expect_obs("raster_line_off", S_FALL, 100, 50, 0, 0, 4'h0, 0);
        bus.screen_x = '0;
        bus.screen_y = '0;

        frames(3);
        expect_obs("fall_3", S_FALL, 100, 62, 0, 0, 4'h0, 0);
        frames(104);
        expect_obs("fall_107", S_FALL, 100, 478, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("offscreen", S_COOL, 100, 482, 0, 0, 4'h0, 0);
        frames(29);
        expect_obs("miss_cool_29", S_COOL, 100, 482, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("miss_idle", S_IDLE, 100, 482, 0, 0, 4'h0, 0);

        // Hit path, with drop held high (and drop_x/drop_y changed) while busy.
        bus.drop   = 1'b1;
        bus.drop_x = 16'sd310;
        bus.drop_y = 16'sd380;
        tick();
        bus.drop_x = 16'sd7;
        bus.drop_y = 16'sd9;
        expect_obs("hit_drop", S_FALL, 310, 380, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("hit_f1", S_FALL, 310, 384, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("hit_f2", S_FALL, 310, 388, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("edge_touch", S_FALL, 310, 392, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("ship_hit", S_EXPL, 310, 396, 1, 0, 4'h0, 0);
        tick();
        expect_obs("hit_pulse_end", S_EXPL, 310, 396, 0, 0, 4'h0, 0);
        frames(7);
        expect_obs("explode_7", S_EXPL, 310, 396, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("explode_done", S_COOL, 310, 396, 0, 0, 4'h0, 0);
        frames(29);
        expect_obs("busy_cool_29", S_COOL, 310, 396, 0, 0, 4'h0, 0);
        frames(1);
        expect_obs("busy_idle", S_IDLE, 310, 396, 0, 0, 4'h0, 0);
        tick();
        expect_obs("busy_relatch", S_FALL, 7, 9, 0, 0, 4'h0, 0);
        bus.drop = 1'b0;

        // Reset while falling.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_obs("reset_mid", S_IDLE, 0, 0, 0, 0, 4'h0, 0);

        bus.drop   = 1'b1;
        bus.drop_x = 16'sd100;
        bus.drop_y = 16'sd100;
        tick();
        bus.drop = 1'b0;
        expect_obs("post_reset_drop", S_FALL, 100, 100, 0, 0, 4'h0, 0);

        bus.speed = 8'd0;
        frames(1);
        expect_obs("speed_zero", S_FALL, 100, 100, 0, 0, 4'h0, 0);

        bus.speed = 8'd4;
`ifdef BOMB_CANCEL_EN
        bus.bullet_x      = 16'sd100;
        bus.bullet_y      = 16'sd104;
        bus.bullet_active = 1'b1;
        frames(1);
        expect_obs("cancel", S_EXPL, 100, 104, 0, 0, 4'h0, 1);
        tick();
        expect_obs("cancel_end", S_EXPL, 100, 104, 0, 0, 4'h0, 0);
        bus.bullet_active = 1'b0;
`else
        frames(1);
        expect_obs("no_cancel", S_FALL, 100, 104, 0, 0, 4'h0, 0);
`endif

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        tick();
        checks++;
        if (hit_seen == 1) passes++;
        else $display("FAIL hit_count: got %0d hit cycles, required 1", hit_seen);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alien_bomb.md
Name: alien_bomb

Overview:
- Downward-travelling projectile dropped by the invader formation toward the player spaceship; the counterpart of the player's upward bullet.
- Accepts a drop request with a launch position and moves the bomb down by `speed` pixels per frame.
- Detects overlap with the spaceship and reports a one-cycle `hit`.
- Supplies `drawing`/`pixel` to the video mixer, the same way the bullet does.

Parameters:
- SCREEN_H, 480: bottom screen limit in pixels; the bomb retires at y >= SCREEN_H.
- BOMB_W, 2: bomb width in pixels.
- BOMB_H, 8: bomb height in pixels.
- SHIP_W, 32: spaceship hitbox width.
- SHIP_H, 16: spaceship hitbox height.
- EXPLODE_FRAMES, 8: frames spent in EXPLODING; must be >= 1.
- COOLDOWN_FRAMES, 30: frames before a new drop is accepted; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- drop  in  1  drop request; level sampled each clk.
- drop_x, drop_y  in  16 signed  launch top-left position.
- frame  in  1  one-clk pulse per video frame.
- screen_line  in  1  high while the raster is in the active region.
- speed  in  8 unsigned  pixels moved per frame.
- screen_x, screen_y  in  16 signed  current raster position.
- spaceship_x, spaceship_y  in  16 signed  ship top-left position.
- drawing  out  1  bomb pixel present at the raster position.
- pixel  out  4  colour index.
- bomb_x, bomb_y  out  16 signed  bomb top-left position.
- bomb_state  out  4  one-hot state.
- hit  out  1  one-clk pulse when the bomb strikes the ship.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): the following hold on the next clk and rst has priority over every event.
  - bomb_state=0001 (IDLE); bomb_x=bomb_y=0; hit=0; drawing=0; pixel=0; frame counter=0.
- States (one-hot): IDLE 0001, FALLING 0010, EXPLODING 0100, COOLDOWN 1000.
- IDLE:
  - drop=1 latches bomb_x<=drop_x and bomb_y<=drop_y, and enters FALLING on the same edge.
  - A frame pulse in the same cycle causes no movement.
- FALLING, on a frame pulse:
  - next_y = bomb_y + {8'b0,speed}, 16-bit signed wrap-free arithmetic; bomb_y<=next_y.
  - If rect(bomb_x,next_y,BOMB_W,BOMB_H) overlaps rect(spaceship_x,spaceship_y,SHIP_W,SHIP_H): hit=1 for exactly that clk, go to EXPLODING, counter<=EXPLODE_FRAMES-1.
  - Else if next_y >= SCREEN_H: go to COOLDOWN, counter<=COOLDOWN_FRAMES-1.
  - A hit takes priority over going off-screen.
  - speed=0 holds position; the overlap is still checked every frame.
- Overlap rule: half-open intervals [x, x+W), signed compares; rectangles that only touch edges do not overlap.
- EXPLODING: each frame, counter==0 goes to COOLDOWN (counter<=COOLDOWN_FRAMES-1); otherwise counter decrements.
- COOLDOWN: each frame, counter==0 goes to IDLE; otherwise counter decrements.
- drop is ignored outside IDLE; requests are not queued.
- Drawing (registered, 1-clk latency from screen_x/screen_y):
  - drawing<=screen_line && state in {FALLING, EXPLODING} && raster inside rect(bomb_x, bomb_y, BOMB_W, BOMB_H).
  - pixel<=4'hC when FALLING, 4'hE when EXPLODING, 4'h0 when not drawing.
- bomb_x/bomb_y hold their last values in EXPLODING, COOLDOWN and IDLE.

Optional Feature:
- BOMB_CANCEL_EN defined:
  - Adds inputs bullet_x and bullet_y (16 signed) and bullet_active (1), using the bullet's 2x8 footprint, plus output cancel (1).
  - In FALLING, on a frame pulse, if bullet_active and the bullet rect overlaps the new bomb rect with no ship hit: cancel=1 for one clk, go to EXPLODING.
  - A ship hit wins over cancel.
- Undefined: these ports do not exist and cancellation never occurs.

Decomposition:
- invaders_pkg:
  - coord_t: signed [15:0].
  - bomb_state_t: one-hot enum.
  - Colour constants BOMB_COLOR=4'hC and EXPLODE_COLOR=4'hE.
  - Bullet footprint constants BULLET_W=2 and BULLET_H=8.
- One combinational sub-module, rect_overlap (two rects in, overlap out). It is reused for the ship hit, the cancel check, and the raster test (as a 1x1 rect).

Test Plan:
- Reset: rst=1 for 2 clk mid-FALLING → next clk bomb_state=0001, drawing=0, hit=0; the next drop is accepted.
- Miss path: drop at (100,50), speed=4, ship (300,400).
  - Next clk: FALLING, bomb_y=50.
  - After 3 frames: bomb_y=62.
  - Frame 108: bomb_y=482, COOLDOWN.
  - 30 frames later: IDLE; hit never asserted.
- Hit path: drop at (310,380), speed=4, ship (300,400).
  - Frames 1-3: y=384/388/392, no hit (edge touch at 392).
  - Frame 4: y=396, hit=1 for exactly 1 clk, EXPLODING.
  - After 8 frames: COOLDOWN.
- Busy drop: drop=1 held throughout FALLING, EXPLODING and COOLDOWN → bomb_x/bomb_y are unchanged by drop_x/drop_y until IDLE is re-entered.
- Raster: bomb FALLING at (100,50), screen_line=1.
  - Raster (101,57) → next clk drawing=1, pixel=4'hC.
  - Raster (101,58) or (102,57) → drawing=0, pixel=0.
  - screen_line=0 → drawing=0.
- BOMB_CANCEL_EN: bomb at y=100, speed=4, bullet_active=1 at (100,104), ship far away → on the frame: cancel=1 for 1 clk, EXPLODING, hit=0.
